ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional watchdog abort enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       wrn,
    input  logic [7:0] din,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);

    logic [1:0]  clk_sync_q;
    logic        clk_prev_q;
    logic [1:0]  data_sync_q;
    logic        clk_s;
    logic        data_s;
    logic        clk_fall;

    logic [2:0]  state_q,    state_d;
    logic [7:0]  data_q,     data_d;
    logic        parity_q,   parity_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [19:0] cnt_q,      cnt_d;
    logic        clk_low_q,  clk_low_d;
    logic        data_low_q, data_low_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        ack_err_q,  ack_err_d;
    logic [19:0] cnt_inc;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic        timeout_q,  timeout_d;
`endif

    // The PS/2 lines are asynchronous to clk; the third clock flop gives the edge reference.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            clk_prev_q  <= clk_sync_q[1];
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 20'd1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch can be inferred.
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                busy_d     = 1'b0;
                if (!wrn) begin
                    data_d    = din;
                    parity_d  = ~^din;
                    ack_err_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    busy_d    = 1'b1;
                    cnt_d     = 20'd0;
                    clk_low_d = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_low_d = 1'b1;
                    cnt_d      = 20'd0;
                    state_d    = ST_RTS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RTS: begin
                clk_low_d = 1'b0;
                bit_cnt_d = 4'd0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Falls 1..8 put data LSB first, fall 9 parity, fall 10 releases for the stop bit.
                if (clk_fall) begin
                    if (bit_cnt_q < 4'd8) begin
                        data_low_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_low_d = ~parity_q;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = ST_ACK;
                    end
                    if (bit_cnt_q != 4'd11) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    ack_err_d = data_s;
                    state_d   = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // The counter restarts at RTS entry and doubles as the watchdog until the transfer ends.
        if (state_q inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
            if (cnt_q == WD_LAST) begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                timeout_d  = 1'b1;
                ack_err_d  = 1'b1;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end else begin
                cnt_d = cnt_inc;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            data_q     <= 8'd0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            cnt_q      <= 20'd0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_err      = ack_err_q;

endmodule
